// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - SHA-1 message padder: packs a byte stream into padded 512-bit blocks.
// Optional abort input is enabled by defining SHA1_PAD_ABORT_EN.
module sha1_padder #(
    parameter int LEN_W     = 64,
    parameter int BLK_BYTES = 64
) (
`ifdef SHA1_PAD_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [BLK_BYTES*8-1:0] blk_data,
    output logic                   blk_valid,
    input  logic                   blk_ready,
    output logic                   blk_first,
    output logic                   blk_last,
    output logic                   busy
);
    localparam int BLK_BITS = BLK_BYTES * 8;

    typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_LENBLK} state_t;

    state_t              state_q;
    logic [BLK_BITS-1:0] buf_q;
    logic [5:0]          ptr_q;
    logic [LEN_W-1:0]    bitlen_q;
    logic                first_pending_q;
    logic [1:0]          pad_next_q;
    logic                msg_act_q;
    logic                blk_valid_q;
    logic                blk_first_q;
    logic                blk_last_q;

    logic [BLK_BITS-1:0] buf_fill_d;
    logic [BLK_BITS-1:0] buf_pad_d;
    logic [63:0]         len64;

    assign len64 = 64'(bitlen_q);

    // Byte slot i lives at bits [(63-i)*8 +: 8] so slot 0 is the most significant byte.
    always_comb begin
        buf_fill_d = buf_q;
        buf_pad_d  = buf_q;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (6'(i) == ptr_q) begin
                buf_fill_d[(BLK_BYTES-1-i)*8 +: 8] = in_data;
                buf_pad_d[(BLK_BYTES-1-i)*8 +: 8]  = 8'h80;
            end else if (6'(i) > ptr_q) begin
                buf_pad_d[(BLK_BYTES-1-i)*8 +: 8]  = 8'h00;
            end
        end
        if (ptr_q <= 6'd55) begin
            buf_pad_d[63:0] = len64;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_FILL;
            buf_q           <= '0;
            ptr_q           <= '0;
            bitlen_q        <= '0;
            first_pending_q <= 1'b1;
            pad_next_q      <= 2'd0;
            msg_act_q       <= 1'b0;
            blk_valid_q     <= 1'b0;
            blk_first_q     <= 1'b0;
            blk_last_q      <= 1'b0;
        end
`ifdef SHA1_PAD_ABORT_EN
        else if (abort) begin
            state_q         <= S_FILL;
            buf_q           <= '0;
            ptr_q           <= '0;
            bitlen_q        <= '0;
            first_pending_q <= 1'b1;
            pad_next_q      <= 2'd0;
            msg_act_q       <= 1'b0;
            blk_valid_q     <= 1'b0;
            blk_first_q     <= 1'b0;
            blk_last_q      <= 1'b0;
        end
`endif
        else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid) begin
                        buf_q     <= buf_fill_d;
                        ptr_q     <= ptr_q + 6'd1;
                        bitlen_q  <= bitlen_q + LEN_W'(8);
                        msg_act_q <= 1'b1;
                        if (ptr_q == 6'd63) begin
                            state_q     <= S_EMIT;
                            blk_valid_q <= 1'b1;
                            blk_first_q <= first_pending_q;
                            blk_last_q  <= 1'b0;
                            pad_next_q  <= in_last ? 2'd1 : 2'd0;
                        end else if (in_last) begin
                            state_q <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    buf_q       <= buf_pad_d;
                    state_q     <= S_EMIT;
                    blk_valid_q <= 1'b1;
                    blk_first_q <= first_pending_q;
                    if (ptr_q <= 6'd55) begin
                        blk_last_q <= 1'b1;
                        pad_next_q <= 2'd0;
                    end else begin
                        blk_last_q <= 1'b0;
                        pad_next_q <= 2'd2;
                    end
                end
                S_EMIT: begin
                    if (blk_ready) begin
                        buf_q           <= '0;
                        ptr_q           <= '0;
                        blk_valid_q     <= 1'b0;
                        first_pending_q <= 1'b0;
                        pad_next_q      <= 2'd0;
                        if (blk_last_q) begin
                            bitlen_q        <= '0;
                            first_pending_q <= 1'b1;
                            msg_act_q       <= 1'b0;
                            state_q         <= S_FILL;
                        end else begin
                            case (pad_next_q)
                                2'd1:    state_q <= S_PAD;
                                2'd2:    state_q <= S_LENBLK;
                                default: state_q <= S_FILL;
                            endcase
                        end
                    end
                end
                S_LENBLK: begin
                    buf_q       <= {{(BLK_BITS-64){1'b0}}, len64};
                    state_q     <= S_EMIT;
                    blk_valid_q <= 1'b1;
                    blk_first_q <= first_pending_q;
                    blk_last_q  <= 1'b1;
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign in_ready  = (state_q == S_FILL) && !reset;
    assign blk_data  = buf_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign busy      = (state_q != S_FILL) || (ptr_q != 6'd0) || msg_act_q;

endmodule

// File: tb/tb_sha1_padder.sv
// tb/tb_sha1_padder.sv - self-checking bench for sha1_padder against a padded-message reference model.
module tb_sha1_padder;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;
    logic         busy;
`ifdef SHA1_PAD_ABORT_EN
    logic         abort = 1'b0;
`endif

    sha1_padder dut (
`ifdef SHA1_PAD_ABORT_EN
        .abort     (abort),
`endif
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    typedef struct {
        int          len;
        int          pat;
        int          nblk;
        logic [63:0] lenf;
    } vec_t;

    blk_t         exp_q[$];
    blk_t         got_q[$];
    logic [7:0]   msg[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [511:0] abc_exp;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_msg(input int len, input int pat);
        msg.delete();
        for (int i = 0; i < len; i++) begin
            case (pat)
                0:       msg.push_back(8'h41);
                1:       msg.push_back(8'(i));
                2:       msg.push_back(8'(8'h61 + i));
                default: msg.push_back(8'($urandom));
            endcase
        end
    endtask

    // Reference: message || 0x80 || zeros to 56 mod 64 || 64-bit big-endian bit length.
    task automatic build_exp();
        logic [7:0]  q[$];
        logic [63:0] bits;
        logic [511:0] d;
        int nb;
        exp_q.delete();
        q = msg;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) q.push_back(bits[k*8 +: 8]);
        nb = q.size() / 64;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int j = 0; j < 64; j++) d[(63-j)*8 +: 8] = q[b*64+j];
            exp_q.push_back('{d, b == 0, b == nb - 1});
        end
    endtask

    task automatic run_msg(input bit rnd);
        int idx, cyc, n;
        bit done, acc, take;
        got_q.delete();
        build_exp();
        idx = 0; cyc = 0; done = 0;
        while (!done && cyc < 4000) begin
            in_valid  = (idx < msg.size()) && (!rnd || $urandom_range(0, 3) != 0);
            in_data   = (idx < msg.size()) ? msg[idx] : 8'h00;
            in_last   = in_valid ? (idx == msg.size() - 1) : (rnd ? 1'($urandom) : 1'b0);
            blk_ready = rnd ? 1'($urandom) : 1'b1;
            acc  = in_valid && in_ready;
            take = blk_valid && blk_ready;
            if (take) begin
                got_q.push_back('{blk_data, blk_first, blk_last});
                if (blk_last) done = 1;
            end
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 0; in_last = 0; blk_ready = 0;
        chk("msg_done", done, 1'b1);
        chk("msg_nblk", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int b = 0; b < n; b++) begin
            chk($sformatf("blk%0d_data", b), got_q[b].d, exp_q[b].d);
            chk($sformatf("blk%0d_first", b), got_q[b].f, exp_q[b].f);
            chk($sformatf("blk%0d_last", b), got_q[b].l, exp_q[b].l);
        end
    endtask

    task automatic send_plain(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_data = msg[i]; in_last = 0;
            tick();
        end
        in_valid = 0;
    endtask

    initial begin
        vec_t vt[8];
        vt = '{'{3, 2, 1, 64'h18}, '{55, 0, 1, 64'h1B8}, '{56, 0, 2, 64'h1C0},
               '{64, 1, 2, 64'h200}, '{1, 1, 1, 64'h8}, '{63, 1, 2, 64'h1F8},
               '{128, 1, 3, 64'h400}, '{120, 0, 3, 64'h3C0}};
        abc_exp = {32'h61626380, 416'h0, 64'h18};

        reset = 1; in_valid = 0; in_last = 0; in_data = 0; blk_ready = 0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 0;
        #1;
        chk("rst_in_ready_after", in_ready, 1'b1);
        chk("rst_blk_valid", blk_valid, 1'b0);
        chk("rst_blk_data", blk_data, 512'h0);
        chk("rst_blk_first", blk_first, 1'b0);
        chk("rst_blk_last", blk_last, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // "abc" with exact latency: last byte accepted at N, block valid at N+2.
        make_msg(3, 2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = msg[i]; in_last = (i == 2);
            chk("abc_in_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 0; in_last = 0;
        chk("abc_valid_n1", blk_valid, 1'b0);
        tick();
        chk("abc_valid_n2", blk_valid, 1'b1);
        chk("abc_data", blk_data, abc_exp);
        chk("abc_first", blk_first, 1'b1);
        chk("abc_last", blk_last, 1'b1);
        chk("abc_in_ready_emit", in_ready, 1'b0);
        blk_ready = 1;
        tick();
        blk_ready = 0;
        chk("abc_valid_after", blk_valid, 1'b0);
        chk("abc_in_ready_after", in_ready, 1'b1);
        chk("abc_busy_after", busy, 1'b0);

        foreach (vt[i]) begin
            make_msg(vt[i].len, vt[i].pat);
            run_msg(i % 2);
            chk("tbl_nblk", got_q.size(), vt[i].nblk);
            if (got_q.size() > 0) chk("tbl_lenf", got_q[got_q.size()-1].d[63:0], vt[i].lenf);
        end

        // Backpressure on a full raw block; bytes offered meanwhile must be ignored.
        make_msg(64, 1);
        build_exp();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1; in_data = msg[i]; in_last = (i == 63);
            tick();
        end
        in_valid = 1; in_data = 8'hEE; in_last = 1;
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", blk_valid, 1'b1);
            chk("bp_data", blk_data, exp_q[0].d);
            chk("bp_first", blk_first, 1'b1);
            chk("bp_last", blk_last, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        in_valid = 0; in_last = 0; blk_ready = 1;
        tick();
        for (int w = 0; w < 10 && !blk_valid; w++) tick();
        chk("bp_wait2", blk_valid, 1'b1);
        chk("bp_data2", blk_data, exp_q[1].d);
        chk("bp_first2", blk_first, 1'b0);
        chk("bp_last2", blk_last, 1'b1);
        tick();
        blk_ready = 0;
        make_msg(5, 3);
        run_msg(0);

        // Reset mid-message discards partial data and length.
        make_msg(10, 3);
        send_plain(10);
        reset = 1;
        tick();
        chk("mid_rst_in_ready", in_ready, 1'b0);
        reset = 0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", blk_valid, 1'b0);
        make_msg(3, 2);
        run_msg(0);
        if (got_q.size() > 0) chk("mid_rst_abc", got_q[0].d, abc_exp);

`ifdef SHA1_PAD_ABORT_EN
        make_msg(10, 3);
        send_plain(10);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", busy, 1'b0);
        make_msg(3, 2);
        run_msg(0);
        if (got_q.size() > 0) chk("abort_abc", got_q[0].d, abc_exp);
`endif

        for (int r = 0; r < 15; r++) begin
            make_msg($urandom_range(1, 200), 3);
            run_msg(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
